// File: rtl/tx_ser_pkg.sv
// -----------------------------------------------------------------------------
// tx_ser_pkg
// Shared definitions for the word serializer:
//   tx_state_e  - serializer FSM state encoding (IDLE, SHIFT, DONE)
//   IDLE_LEVEL  - level driven on the serial line whenever no bit is presented
// -----------------------------------------------------------------------------
package tx_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  localparam logic IDLE_LEVEL = 1'b1;

endpackage : tx_ser_pkg

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Programmable-rollover up counter. After a clear it sits at 0; when enabled it
// counts 1..rollover_val and wraps back to 1.
//
// Ports:
//   clk           in   system clock, rising edge
//   n_rst         in   asynchronous active-low reset (count_out -> 0)
//   clear         in   synchronous clear to 0, dominates count_enable
//   count_enable  in   advance the count this cycle
//   rollover_val  in   terminal count (NUM_CNT_BITS)
//   count_out     out  current count (NUM_CNT_BITS)
//   rollover_flag out  high in the cycle whose rising edge loads rollover_val,
//                      i.e. the cycle that completes a full count period
// -----------------------------------------------------------------------------
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;

  always_comb begin
    next_count = count_out + NUM_CNT_BITS'(1);
    if (count_out == rollover_val) begin
      next_count = NUM_CNT_BITS'(1);
    end
  end

  // Flag is combinational so the consumer can act on the same edge at which
  // the period completes, without a one-cycle lag.
  assign rollover_flag = count_enable && !clear && (next_count == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= next_count;
    end
  end

endmodule : flex_counter

// File: rtl/tx_word_serializer.sv
// -----------------------------------------------------------------------------
// tx_word_serializer
// Accepts a parallel word through a valid/ready handshake and shifts it out on
// serial_out, holding each bit for CLKS_PER_BIT cycles. A one-cycle done pulse
// follows the final bit period, then the block returns to IDLE.
//
// Handshake: a word transfers on a rising edge where load_valid=1 and
// load_ready=1 (and abort=0). load_ready is high only in IDLE; load_valid may
// be held high to stream words back to back. load_data is only sampled on the
// transfer edge.
//
// Ports:
//   clk          in   system clock, rising edge
//   n_rst        in   asynchronous active-low reset
//   load_valid   in   upstream offers load_data
//   load_data    in   parallel word (NUM_BITS)
//   load_ready   out  block can accept a word this cycle
//   abort        in   synchronous cancel; dominates the handshake
//   serial_out   out  serial line, idles at IDLE_LEVEL
//   busy         out  a word is being shifted
//   done         out  one-cycle pulse after the last bit period
//   dbg_state    out  FSM state
//   dbg_bit_idx  out  index of the bit currently on the line
//   dbg_bit_cnt  out  bit-period counter value
// -----------------------------------------------------------------------------
module tx_word_serializer
  import tx_ser_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              load_valid,
  input  logic [NUM_BITS-1:0]               load_data,
  output logic                              load_ready,
  input  logic                              abort,
  output logic                              serial_out,
  output logic                              busy,
  output logic                              done,
  output tx_state_e                         dbg_state,
  output logic [$clog2(NUM_BITS+1)-1:0]     dbg_bit_idx,
  output logic [$clog2(CLKS_PER_BIT+1)-1:0] dbg_bit_cnt
);

  localparam int IDX_W = $clog2(NUM_BITS + 1);
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CPB_VAL  = CNT_W'(CLKS_PER_BIT);

  tx_state_e           state;
  tx_state_e           next_state;
  logic [NUM_BITS-1:0] shift_q;
  logic [IDX_W-1:0]    bit_idx;
  logic [CNT_W-1:0]    bit_cnt;

  logic handshake;
  logic period_end;
  logic last_bit;
  logic timer_clear;
  logic timer_enable;

  // abort has priority: an abort in IDLE blocks the capture entirely.
  assign handshake = (state == IDLE) && load_valid && !abort;

  // ---------------------------------------------------------------------------
  // Bit-period timer
  // ---------------------------------------------------------------------------
  assign timer_enable = (state == SHIFT);
  assign timer_clear  = handshake || abort || (state == DONE);

  flex_counter #(
    .NUM_CNT_BITS (CNT_W)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (timer_clear),
    .count_enable  (timer_enable),
    .rollover_val  (CPB_VAL),
    .count_out     (bit_cnt),
    .rollover_flag (period_end)
  );

  assign last_bit = period_end && (bit_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    serial_out = IDLE_LEVEL;
    unique case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (handshake) begin
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = MSB_FIRST ? shift_q[NUM_BITS-1] : shift_q[0];
        if (abort) begin
          next_state = IDLE;
        end else if (last_bit) begin
          next_state = DONE;
        end
      end
      DONE: begin
        // A cancel landing on the DONE cycle suppresses the completion pulse.
        done       = !abort;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift register and bit index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q <= '0;
    end else if (handshake) begin
      shift_q <= load_data;
    end else if (period_end && !abort) begin
      // Advance toward the output end; the vacated end fills with 0.
      if (MSB_FIRST) begin
        shift_q <= {shift_q[NUM_BITS-2:0], 1'b0};
      end else begin
        shift_q <= {1'b0, shift_q[NUM_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_idx <= '0;
    end else if (handshake || abort || (state == DONE)) begin
      bit_idx <= '0;
    end else if (period_end) begin
      bit_idx <= bit_idx + IDX_W'(1);
    end
  end

  assign dbg_state   = state;
  assign dbg_bit_idx = bit_idx;
  assign dbg_bit_cnt = bit_cnt;

endmodule : tx_word_serializer

// File: tb/tb_tx_word_serializer.sv
module tb_tx_word_serializer;
  import tx_ser_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  // Three instances: [0] 8/4/MSB, [1] 8/4/LSB, [2] 8/1/MSB
  logic [2:0] lv;
  logic [2:0] ab;
  logic [7:0] ld [3];
  logic [2:0] rdy;
  logic [2:0] so;
  logic [2:0] bsy;
  logic [2:0] dn;
  tx_state_e  st [3];
  logic [3:0] bidx [3];
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic       cnt2;

  tx_word_serializer #(.NUM_BITS(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[0]), .load_data(ld[0]),
    .load_ready(rdy[0]), .abort(ab[0]), .serial_out(so[0]), .busy(bsy[0]),
    .done(dn[0]), .dbg_state(st[0]), .dbg_bit_idx(bidx[0]), .dbg_bit_cnt(cnt0)
  );

  tx_word_serializer #(.NUM_BITS(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[1]), .load_data(ld[1]),
    .load_ready(rdy[1]), .abort(ab[1]), .serial_out(so[1]), .busy(bsy[1]),
    .done(dn[1]), .dbg_state(st[1]), .dbg_bit_idx(bidx[1]), .dbg_bit_cnt(cnt1)
  );

  tx_word_serializer #(.NUM_BITS(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) dut_fast (
    .clk(clk), .n_rst(n_rst), .load_valid(lv[2]), .load_data(ld[2]),
    .load_ready(rdy[2]), .abort(ab[2]), .serial_out(so[2]), .busy(bsy[2]),
    .done(dn[2]), .dbg_state(st[2]), .dbg_bit_idx(bidx[2]), .dbg_bit_cnt(cnt2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input string name, input logic act);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty @%0t", name, $time);
    end else begin
      e = exp_q.pop_front();
      chk(name, 32'(act), 32'(e));
    end
  endtask

  function automatic int cpb_of(input int sel);
    return (sel == 2) ? 1 : 4;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  // expected {done,busy,load_ready,serial_out}
  function automatic logic [3:0] flags(input int sel);
    return {dn[sel], bsy[sel], rdy[sel], so[sel]};
  endfunction

  task automatic push_word(input logic [7:0] exp_bits, input int cpb);
    for (int b = 7; b >= 0; b--)
      for (int k = 0; k < cpb; k++) exp_q.push_back(exp_bits[b]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one full word, called at a negedge with the DUT idle
  // ---------------------------------------------------------------------------
  task automatic run_word(input int sel, input logic [7:0] data,
                          input logic [7:0] exp_bits, input string tag);
    int cpb;
    int nc;
    cpb = cpb_of(sel);
    nc  = 8 * cpb;
    chk({tag, "_ready_idle"}, 32'(rdy[sel]), 32'd1);
    lv[sel] = 1'b1;
    ld[sel] = data;
    push_word(exp_bits, cpb);
    for (int c = 1; c <= nc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        lv[sel] = 1'b0;
        ld[sel] = 8'($urandom_range(0, 255));
      end
      pop_chk({tag, "_bit"}, so[sel]);
      chk({tag, "_shift_flags"}, 32'(flags(sel) & 4'b1110), 32'b0100);
    end
    @(negedge clk);
    chk({tag, "_done_cycle"}, 32'(flags(sel)), 32'b1001);
    @(negedge clk);
    chk({tag, "_back_idle"}, 32'(flags(sel)), 32'b0011);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] exp_bits;   // bits in line order, first-sent at [7]
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] r;
    int         done_seen;

    vecs[0] = '{0, 8'hA5, 8'hA5};
    vecs[1] = '{0, 8'h3C, 8'h3C};
    vecs[2] = '{1, 8'h01, 8'h80};
    vecs[3] = '{1, 8'hB2, 8'h4D};
    vecs[4] = '{2, 8'h81, 8'h81};
    vecs[5] = '{2, 8'h6E, 8'h6E};
    r = 8'($urandom_range(0, 255));
    vecs[6] = '{0, r, r};
    r = 8'($urandom_range(0, 255));
    vecs[7] = '{1, r, rev8(r)};

    n_rst = 1'b0;
    lv = '0;
    ab = '0;
    for (int i = 0; i < 3; i++) ld[i] = 8'h00;

    // Reset values, before any clock edge
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_flags_%0d", i), 32'(flags(i)), 32'b0011);
      chk($sformatf("reset_state_%0d", i), 32'(st[i]), 32'(IDLE));
      chk($sformatf("reset_idx_%0d", i), 32'(bidx[i]), 32'd0);
    end
    chk("reset_cnt_0", 32'(cnt0), 32'd0);
    chk("reset_cnt_1", 32'(cnt1), 32'd0);
    chk("reset_cnt_2", 32'(cnt2), 32'd0);

    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Table-driven words (first one hits the first edge after reset release)
    for (int v = 0; v < 8; v++) begin
      run_word(vecs[v].sel, vecs[v].data, vecs[v].exp_bits, $sformatf("vec%0d", v));
    end

    // Back-to-back with load_valid held high
    chk("b2b_ready", 32'(rdy[0]), 32'd1);
    lv[0] = 1'b1;
    ld[0] = 8'hFF;
    push_word(8'hFF, 4);
    push_word(8'h00, 4);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (c == 1) ld[0] = 8'h00;
      pop_chk("b2b_w1_bit", so[0]);
      chk("b2b_w1_flags", 32'(flags(0) & 4'b1110), 32'b0100);
    end
    @(negedge clk);
    chk("b2b_done1", 32'(flags(0)), 32'b1001);
    @(negedge clk);
    chk("b2b_idle_gap", 32'(flags(0)), 32'b0011);
    for (int c = 35; c <= 66; c++) begin
      @(negedge clk);
      if (c == 35) lv[0] = 1'b0;
      pop_chk("b2b_w2_bit", so[0]);
      chk("b2b_w2_flags", 32'(flags(0) & 4'b1110), 32'b0100);
    end
    @(negedge clk);
    chk("b2b_done2", 32'(flags(0)), 32'b1001);
    @(negedge clk);
    chk("b2b_idle_end", 32'(flags(0)), 32'b0011);
    @(negedge clk);
    chk("b2b_no_dup", 32'(bsy[0]), 32'd0);

    // Abort at cycle 10 of a word
    lv[0] = 1'b1;
    ld[0] = 8'h96;
    push_word(8'h96, 4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) lv[0] = 1'b0;
      pop_chk("abort_bit", so[0]);
    end
    ab[0] = 1'b1;
    @(negedge clk);
    chk("abort_idle", 32'(flags(0)), 32'b0011);
    chk("abort_state", 32'(st[0]), 32'(IDLE));
    ab[0] = 1'b0;
    exp_q.delete();
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dn[0] || bsy[0]) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    run_word(0, 8'h3C, 8'h3C, "post_abort");

    // Abort in IDLE beats a concurrent load_valid
    lv[0] = 1'b1;
    ab[0] = 1'b1;
    ld[0] = 8'hF0;
    @(negedge clk);
    lv[0] = 1'b0;
    ab[0] = 1'b0;
    chk("idle_abort_flags", 32'(flags(0)), 32'b0011);
    chk("idle_abort_state", 32'(st[0]), 32'(IDLE));

    // Asynchronous reset at cycle 17 of a word
    lv[0] = 1'b1;
    ld[0] = 8'h5A;
    push_word(8'h5A, 4);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) lv[0] = 1'b0;
      pop_chk("rst_mid_bit", so[0]);
    end
    #2 n_rst = 1'b0;
    #1;
    chk("rst_mid_flags", 32'(flags(0)), 32'b0011);
    chk("rst_mid_state", 32'(st[0]), 32'(IDLE));
    chk("rst_mid_idx", 32'(bidx[0]), 32'd0);
    chk("rst_mid_cnt", 32'(cnt0), 32'd0);
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    run_word(0, 8'hC3, 8'hC3, "post_rst");

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tx_word_serializer

// File: doc/tx_word_serializer.md
TX_WORD_SERIALIZER -- requirements
Module: tx_word_serializer

Interface
REQ-001 Parameter NUM_BITS, default 8: word width in bits; SHALL be at least 2.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each bit is held on serial_out; SHALL be at least 1.
REQ-003 Parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-004 Port clk, input, 1: the single system clock; all state SHALL be clocked on its rising edge.
REQ-005 Port n_rst, input, 1: asynchronous, active-low reset.
REQ-006 Port load_valid, input, 1: upstream has a word on load_data.
REQ-007 Port load_data, input, NUM_BITS: parallel word to transmit.
REQ-008 Port load_ready, output, 1: block accepts a word this cycle.
REQ-009 Port abort, input, 1: synchronous cancel of the current word.
REQ-010 Port serial_out, output, 1: serial line; idle level is 1.
REQ-011 Port busy, output, 1: high while a word is being shifted.
REQ-012 Port done, output, 1: one-cycle pulse after the last bit period completes.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 IDLE outputs SHALL be: load_ready=1, busy=0, done=0, serial_out=1.
REQ-015 A handshake occurs when load_valid=1 and load_ready=1 at a rising edge.
- On that edge, load_data SHALL be captured into the shift register.
- The bit-period and bit-index counters SHALL be cleared.
- The FSM SHALL move to SHIFT.
REQ-016 In SHIFT, serial_out SHALL present the current bit, so the first bit appears in the cycle immediately after the handshake.
REQ-017 In SHIFT and DONE, load_ready SHALL be 0; in SHIFT, busy SHALL be 1.
REQ-018 Each bit SHALL be held exactly CLKS_PER_BIT cycles before the shift register advances one position toward the output end.
REQ-019 The bit-period counter SHALL count 1..CLKS_PER_BIT and wrap to 1; its rollover increments the bit index.
REQ-020 Bit index width SHALL be $clog2(NUM_BITS+1); bit-period counter width SHALL be $clog2(CLKS_PER_BIT+1).
REQ-021 When the last bit period of bit NUM_BITS-1 ends, the FSM SHALL enter DONE for exactly one cycle.
- In that cycle: done=1, busy=0, serial_out=1.
- The FSM SHALL then return to IDLE.
REQ-022 The total SHIFT duration SHALL be NUM_BITS*CLKS_PER_BIT cycles; done SHALL assert on cycle NUM_BITS*CLKS_PER_BIT+1 after the handshake edge.
REQ-023 abort=1 in SHIFT or DONE SHALL force IDLE on the next edge, with serial_out=1 and no done pulse.
REQ-024 abort=1 in IDLE together with load_valid=1 SHALL suppress the capture, because abort has priority over the handshake.
REQ-025 load_valid held high continuously SHALL produce back-to-back words, with exactly one DONE cycle between them; no word SHALL be captured outside IDLE.
REQ-026 load_data changes outside the handshake cycle SHALL NOT affect the word in flight.

Reset
REQ-027 n_rst=0 SHALL immediately force IDLE, asynchronously and mid-word included.
- Outputs SHALL be: serial_out=1, busy=0, done=0, load_ready=1.
- The shift register and both counters SHALL be cleared to 0.
REQ-028 After n_rst deasserts, the first handshake is possible at the first rising edge.

Structure
REQ-029 Package tx_ser_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE) and the idle-line-level constant.
REQ-030 The bit-period timer SHALL be an instance of the existing flex_counter.
- NUM_CNT_BITS = $clog2(CLKS_PER_BIT+1).
- rollover_val = CLKS_PER_BIT.
- count_enable = SHIFT state.
- clear = handshake, abort or DONE.
REQ-031 The FSM, shift register and bit-index counter SHALL live in tx_word_serializer itself.

Verification (NUM_BITS=8, CLKS_PER_BIT=4, MSB_FIRST=1 unless stated)
REQ-032 Load 8'hA5 -> serial_out = 1,0,1,0,0,1,0,1 with each bit held 4 cycles; done pulses once at cycle 33 after the handshake; load_ready returns to 1 at cycle 34.
REQ-033 MSB_FIRST=0, load 8'h01 -> 1 for 4 cycles, then 0 for 28 cycles, then done.
REQ-034 load_valid held high with 8'hFF then 8'h00 -> the second word's first bit starts 2 cycles after the first word's last bit period ends; no word is dropped or duplicated.
REQ-035 abort asserted at cycle 10 of a word -> IDLE and serial_out=1 next cycle, no done; a subsequent load 8'h3C transmits correctly.
REQ-036 n_rst pulsed low at cycle 17 of a word -> outputs take reset values without a clock edge; after release, a load 8'hC3 transmits correctly.
REQ-037 CLKS_PER_BIT=1, load 8'h81 -> bits change every cycle; done asserts at cycle 9.
